// File: rtl/rv_fetch_decode_pkg.sv
// Shared RV32I front-end definitions: base opcodes, fetch FSM encoding and the canonical NOP.
package rv_fetch_decode_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DROP  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/rv_fetch_decode_imm_gen.sv
// Combinational RV32I immediate generator; flags any opcode outside the base set as illegal.
module rv_imm_gen
   import rv_fetch_decode_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output logic        illegal
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      imm     = '0;
      illegal = 1'b0;
      unique case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_OP:
            imm = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {instr[31:12], 12'b0};
         OP_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv_fetch_decode.sv
// RV32I fetch/decode front end: owns the PC, runs a single-outstanding imem req/ack fetch
// and holds one decoded instruction until execute accepts it or redirects.
module rv_fetch_decode
   import rv_fetch_decode_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        ex_ready,
   input  logic        take_jmp,
   input  logic [31:0] jmp_target,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm,
   output logic        illegal,
   output logic        misalign
);

   fetch_state_e state_q;
   logic [31:0]  pc_q, drop_addr_q, pc_out_q, instr_q, imm_q;
   logic         req_q, valid_q, illegal_q, misalign_q;

   logic [31:0]  imm_d;
   logic         illegal_d;
   logic         ack_ok, jmp_bad;

   rv_imm_gen u_imm_gen (
      .instr   (imem_rdata),
      .imm     (imm_d),
      .illegal (illegal_d)
   );

   // An ack only counts against a request that is actually on the bus.
   assign ack_ok  = imem_ack && req_q;
   assign jmp_bad = (jmp_target[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= RESET_PC;
         req_q       <= 1'b0;
         valid_q     <= 1'b0;
         misalign_q  <= 1'b0;
         pc_out_q    <= '0;
         instr_q     <= '0;
         imm_q       <= '0;
         illegal_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (take_jmp) begin
                  valid_q <= 1'b0;
                  if (jmp_bad) begin
                     misalign_q <= 1'b1;
                     req_q      <= 1'b0;
                     state_q    <= ST_ERR;
                  end else begin
                     pc_q  <= jmp_target;
                     req_q <= 1'b1;
                     // A request already on the bus cannot be withdrawn; wait it out in DROP.
                     if (req_q && !imem_ack) begin
                        drop_addr_q <= pc_q;
                        state_q     <= ST_DROP;
                     end
                  end
               end else if (ack_ok) begin
                  instr_q   <= imem_rdata;
                  imm_q     <= imm_d;
                  illegal_q <= illegal_d;
                  pc_out_q  <= pc_q;
                  valid_q   <= 1'b1;
                  req_q     <= 1'b0;
                  state_q   <= ST_HOLD;
               end else begin
                  req_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (take_jmp) begin
                  valid_q <= 1'b0;
                  if (jmp_bad) begin
                     misalign_q <= 1'b1;
                     state_q    <= ST_ERR;
                  end else begin
                     pc_q    <= jmp_target;
                     req_q   <= 1'b1;
                     state_q <= ST_FETCH;
                  end
               end else if (ex_ready) begin
                  pc_q    <= pc_q + 32'd4;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= ST_FETCH;
               end
            end
            ST_DROP: begin
               if (take_jmp && jmp_bad) begin
                  misalign_q <= 1'b1;
                  req_q      <= 1'b0;
                  state_q    <= ST_ERR;
               end else begin
                  if (take_jmp) pc_q <= jmp_target;
                  if (ack_ok)   state_q <= ST_FETCH;
               end
            end
            default: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = (state_q == ST_DROP) ? drop_addr_q : pc_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_out_q;
   assign opcode      = instr_q[6:0];
   assign funct3      = instr_q[14:12];
   assign funct7      = instr_q[31:25];
   assign rd          = instr_q[11:7];
   assign rs1         = instr_q[19:15];
   assign rs2         = instr_q[24:20];
   assign imm         = imm_q;
   assign illegal     = illegal_q && valid_q;
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_rv_fetch_decode.sv
// Directed bench for rv_fetch_decode: reset, fetch/decode, stall, redirects and misalign trap.
module tb_rv_fetch_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        ex_ready;
   logic        take_jmp;
   logic [31:0] jmp_target;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        illegal;
   logic        misalign;

   int n_assert = 0;
   int n_fail   = 0;

   rv_fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ex_ready    (ex_ready),
      .take_jmp    (take_jmp),
      .jmp_target  (jmp_target),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .illegal     (illegal),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ex_ready = 1'b0;
      take_jmp = 1'b0; jmp_target = '0;

      tick(); tick();
      check("rst_req",      imem_req,    0);
      check("rst_valid",    instr_valid, 0);
      check("rst_misalign", misalign,    0);
      check("rst_opcode",   opcode,      0);
      check("rst_imm",      imm,         0);

      rst = 1'b0;
      tick();
      check("first_req",  imem_req,  1);
      check("first_addr", imem_addr, 32'h0);

      // ADDI x1, x0, -5
      imem_ack = 1'b1; imem_rdata = 32'hFFB0_0093;
      tick();
      imem_ack = 1'b0;
      check("addi_valid",  instr_valid, 1);
      check("addi_opcode", opcode,      7'b0010011);
      check("addi_funct3", funct3,      0);
      check("addi_rd",     rd,          1);
      check("addi_rs1",    rs1,         0);
      check("addi_imm",    imm,         32'hFFFF_FFFB);
      check("addi_pc",     pc_out,      32'h0);
      check("addi_req",    imem_req,    0);

      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      check("next_valid", instr_valid, 0);
      check("next_req",   imem_req,    1);
      check("next_addr",  imem_addr,   32'h4);

      // BEQ x0, x0, -4
      imem_ack = 1'b1; imem_rdata = 32'hFE00_0EE3;
      tick();
      imem_ack = 1'b0;
      check("beq_opcode", opcode, 7'b1100011);
      check("beq_imm",    imm,    32'hFFFF_FFFC);
      check("beq_pc",     pc_out, 32'h4);

      ex_ready = 1'b1; tick(); ex_ready = 1'b0;
      check("addr_8", imem_addr, 32'h8);

      // LUI x1, 0x12345
      imem_ack = 1'b1; imem_rdata = 32'h1234_50B7;
      tick();
      imem_ack = 1'b0;
      check("lui_imm",     imm,     32'h1234_5000);
      check("lui_rd",      rd,      1);
      check("lui_illegal", illegal, 0);
      check("lui_pc",      pc_out,  32'h8);

      ex_ready = 1'b1; tick(); ex_ready = 1'b0;
      check("addr_c", imem_addr, 32'hC);

      // All-zero word is not an RV32I opcode
      imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
      tick();
      imem_ack = 1'b0;
      check("zero_valid",   instr_valid, 1);
      check("zero_illegal", illegal,     1);
      check("zero_imm",     imm,         0);
      check("zero_pc",      pc_out,      32'hC);

      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid",   instr_valid, 1);
         check("stall_illegal", illegal,     1);
         check("stall_req",     imem_req,    0);
         check("stall_pc",      pc_out,      32'hC);
      end

      // Redirect beats ex_ready in HOLD
      take_jmp = 1'b1; jmp_target = 32'h100; ex_ready = 1'b1;
      tick();
      take_jmp = 1'b0; ex_ready = 1'b0;
      check("hjmp_valid", instr_valid, 0);
      check("hjmp_req",   imem_req,    1);
      check("hjmp_addr",  imem_addr,   32'h100);

      // Redirect while a fetch of 0x100 is outstanding
      take_jmp = 1'b1; jmp_target = 32'h200;
      tick();
      take_jmp = 1'b0;
      check("drop_req",  imem_req,  1);
      check("drop_addr", imem_addr, 32'h100);
      tick();
      check("drop_addr2", imem_addr, 32'h100);
      tick();
      check("drop_addr3", imem_addr, 32'h100);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
      tick();
      imem_ack = 1'b0;
      check("drop_valid", instr_valid, 0);
      check("drop_req2",  imem_req,    1);
      check("drop_new",   imem_addr,   32'h200);

      // JAL x1, +8 at the redirected address
      imem_ack = 1'b1; imem_rdata = 32'h0080_00EF;
      tick();
      imem_ack = 1'b0;
      check("jal_valid", instr_valid, 1);
      check("jal_imm",   imm,         32'h8);
      check("jal_rd",    rd,          1);
      check("jal_pc",    pc_out,      32'h200);

      // Misaligned redirect traps until reset
      take_jmp = 1'b1; jmp_target = 32'h102;
      tick();
      take_jmp = 1'b0;
      check("mis_flag",  misalign,    1);
      check("mis_valid", instr_valid, 0);
      check("mis_req",   imem_req,    0);
      ex_ready = 1'b1; imem_ack = 1'b1; take_jmp = 1'b1; jmp_target = 32'h300;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("err_flag",  misalign,    1);
         check("err_req",   imem_req,    0);
         check("err_valid", instr_valid, 0);
      end
      ex_ready = 1'b0; imem_ack = 1'b0; take_jmp = 1'b0;

      rst = 1'b1;
      tick();
      check("rst2_misalign", misalign, 0);
      check("rst2_req",      imem_req, 0);
      rst = 1'b0;
      tick();
      check("rst2_req1", imem_req,  1);
      check("rst2_addr", imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
